// File: rtl/mem_stage_sw.sv
// Pipeline memory stage: data-memory access with byte/halfword lanes, optional
// multi-cycle latency with a wait-state FSM, and the M/W pipeline registers.
//
// state | meaning
// IDLE  | ready for a new M instruction; KillM and misalignment evaluated here
// WAIT  | access in flight; counter holds the wait cycles still remaining
module mem_stage_sw #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] IRM,
  input  logic [31:0] PC4M,
  input  logic [31:0] AOM,
  input  logic [31:0] RTM,
  input  logic [3:0]  MemOpM,
  input  logic        FwdSelM,
  input  logic [31:0] WdW,
  input  logic        KillM,
  output logic        StallM,
  output logic [31:0] IRW,
  output logic [31:0] PC4W,
  output logic [31:0] AOW,
  output logic [31:0] DRW,
  output logic        AddrExcW
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [2:0] CNT_INIT = 3'(LATENCY > 0 ? LATENCY - 1 : 0);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] mem_q [DEPTH];
  logic [31:0] ir_w_q, pc4_w_q, ao_w_q, dr_w_q;
  logic        exc_w_q;

  logic              is_mem, is_store, misal, req;
  logic              bubble, complete, mem_we;
  logic [ADDR_W-1:0] widx;
  logic [31:0]       sd, rd_word, shifted, load_val, wr_word;
  logic [15:0]       half_sel;

  assign sd       = FwdSelM ? WdW : RTM;
  assign widx     = AOM[ADDR_W+1:2];
  assign rd_word  = mem_q[widx];
  assign is_mem   = (MemOpM >= 4'd1) && (MemOpM <= 4'd8);
  assign is_store = (MemOpM >= 4'd6) && (MemOpM <= 4'd8);

  always_comb begin
    misal = 1'b0;
    case (MemOpM)
      4'd1, 4'd6:       misal = (AOM[1:0] != 2'b00);
      4'd2, 4'd3, 4'd7: misal = AOM[0];
      default:          misal = 1'b0;
    endcase
  end

  assign req = is_mem && !misal && !KillM;

  assign shifted  = rd_word >> {AOM[1:0], 3'b000};
  assign half_sel = AOM[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_val = '0;
    case (MemOpM)
      4'd1:    load_val = rd_word;
      4'd2:    load_val = {{16{half_sel[15]}}, half_sel};
      4'd3:    load_val = {16'h0000, half_sel};
      4'd4:    load_val = {{24{shifted[7]}}, shifted[7:0]};
      4'd5:    load_val = {24'h000000, shifted[7:0]};
      default: load_val = '0;
    endcase
  end

  // Read-modify-write merge: untouched lanes keep the current word
  always_comb begin
    wr_word = rd_word;
    case (MemOpM)
      4'd6: wr_word = sd;
      4'd7: wr_word[{AOM[1], 4'b0000} +: 16] = sd[15:0];
      4'd8: wr_word[{AOM[1:0], 3'b000} +: 8] = sd[7:0];
      default: wr_word = rd_word;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    StallM   = 1'b0;
    bubble   = 1'b0;
    complete = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (KillM) begin
          bubble = 1'b1;
        end else if (req && (LATENCY > 0)) begin
          StallM  = 1'b1;
          bubble  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = S_WAIT;
        end else begin
          complete = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q != 3'd0) begin
          StallM = 1'b1;
          bubble = 1'b1;
          cnt_d  = cnt_q - 3'd1;
        end else begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // KillM is already excluded on an IDLE completion; WAIT ignores it
  assign mem_we = complete && is_store && !misal;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ir_w_q  <= '0;
      pc4_w_q <= '0;
      ao_w_q  <= '0;
      dr_w_q  <= '0;
      exc_w_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (bubble) begin
        ir_w_q  <= '0;
        pc4_w_q <= '0;
        ao_w_q  <= '0;
        dr_w_q  <= '0;
        exc_w_q <= 1'b0;
      end else if (complete) begin
        ir_w_q  <= IRM;
        pc4_w_q <= PC4M;
        ao_w_q  <= AOM;
        dr_w_q  <= misal ? 32'h0 : load_val;
        exc_w_q <= misal;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[widx] <= wr_word;
    end
  end

  assign IRW      = ir_w_q;
  assign PC4W     = pc4_w_q;
  assign AOW      = ao_w_q;
  assign DRW      = dr_w_q;
  assign AddrExcW = exc_w_q;

endmodule

// File: tb/tb_mem_stage_sw.sv
// Bench for mem_stage_sw: one zero-latency and one three-wait-cycle instance,
// each checked every cycle against a transaction-level model of the stage.
module tb_mem_stage_sw;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] ir_i [2], pc4_i [2], ao_i [2], rt_i [2], wd_i [2];
  logic [3:0]  op_i [2];
  logic        fwd_i [2], kill_i [2];
  logic        stall_o [2], exc_o [2];
  logic [31:0] irw_o [2], pc4w_o [2], aow_o [2], drw_o [2];

  int total = 0;
  int bad = 0;
  int tag = 0;
  bit chk_en = 1'b0;

  mem_stage_sw #(.ADDR_W(10), .LATENCY(0)) u_l0 (
    .Clk(clk), .Reset(rst_n), .IRM(ir_i[0]), .PC4M(pc4_i[0]), .AOM(ao_i[0]),
    .RTM(rt_i[0]), .MemOpM(op_i[0]), .FwdSelM(fwd_i[0]), .WdW(wd_i[0]),
    .KillM(kill_i[0]), .StallM(stall_o[0]), .IRW(irw_o[0]), .PC4W(pc4w_o[0]),
    .AOW(aow_o[0]), .DRW(drw_o[0]), .AddrExcW(exc_o[0]));

  mem_stage_sw #(.ADDR_W(10), .LATENCY(3)) u_l3 (
    .Clk(clk), .Reset(rst_n), .IRM(ir_i[1]), .PC4M(pc4_i[1]), .AOM(ao_i[1]),
    .RTM(rt_i[1]), .MemOpM(op_i[1]), .FwdSelM(fwd_i[1]), .WdW(wd_i[1]),
    .KillM(kill_i[1]), .StallM(stall_o[1]), .IRW(irw_o[1]), .PC4W(pc4w_o[1]),
    .AOW(aow_o[1]), .DRW(drw_o[1]), .AddrExcW(exc_o[1]));

  // ---------------- reference model ----------------
  logic [31:0] mm [2][1024];
  int          age [2];
  logic [31:0] e_ir [2], e_pc4 [2], e_ao [2], e_dr [2];
  logic        e_exc [2];

  function automatic int lat_of(int d);
    return (d == 1) ? 3 : 0;
  endfunction

  function automatic bit is_mem_f(logic [3:0] op);
    return (op >= 1) && (op <= 8);
  endfunction

  function automatic bit misal_f(logic [3:0] op, logic [31:0] ao);
    int a = int'(ao % 4);
    if (op == 1 || op == 6) return a != 0;
    if (op == 2 || op == 3 || op == 7) return (a % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] load_f(logic [3:0] op, logic [31:0] w, logic [31:0] ao);
    int bl = int'(ao % 4);
    int hl = bl / 2;
    logic [7:0]  b = 8'((w >> (8 * bl)) & 32'hFF);
    logic [15:0] h = 16'((w >> (16 * hl)) & 32'hFFFF);
    case (op)
      1: return w;
      2: return 32'($signed(h));
      3: return {16'h0, h};
      4: return 32'($signed(b));
      5: return {24'h0, b};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] store_f(logic [3:0] op, logic [31:0] w, logic [31:0] sd,
                                          logic [31:0] ao);
    int bl = int'(ao % 4);
    logic [31:0] m;
    case (op)
      6: return sd;
      7: begin
        m = 32'hFFFF << (16 * (bl / 2));
        return (w & ~m) | ((sd & 32'hFFFF) << (16 * (bl / 2)));
      end
      8: begin
        m = 32'hFF << (8 * bl);
        return (w & ~m) | ((sd & 32'hFF) << (8 * bl));
      end
      default: return w;
    endcase
  endfunction

  function automatic bit request_now(int d);
    bit k = (age[d] == 0) ? kill_i[d] : 1'b0;
    return is_mem_f(op_i[d]) && !misal_f(op_i[d], ao_i[d]) && !k;
  endfunction

  always @(posedge clk) begin : model
    for (int d = 0; d < 2; d++) begin
      logic        k, rq, mis;
      logic [31:0] old, nw, sd;
      if (!rst_n) begin
        age[d]   <= 0;
        e_ir[d]  <= '0; e_pc4[d] <= '0; e_ao[d] <= '0; e_dr[d] <= '0; e_exc[d] <= 1'b0;
        for (int i = 0; i < 1024; i++) mm[d][i] <= '0;
      end else begin
        k   = (age[d] == 0) ? kill_i[d] : 1'b0;
        mis = misal_f(op_i[d], ao_i[d]);
        rq  = is_mem_f(op_i[d]) && !mis && !k;
        if (rq && age[d] < lat_of(d)) begin
          age[d]   <= age[d] + 1;
          e_ir[d]  <= '0; e_pc4[d] <= '0; e_ao[d] <= '0; e_dr[d] <= '0; e_exc[d] <= 1'b0;
        end else begin
          age[d] <= 0;
          if (k) begin
            e_ir[d]  <= '0; e_pc4[d] <= '0; e_ao[d] <= '0; e_dr[d] <= '0; e_exc[d] <= 1'b0;
          end else begin
            old       = mm[d][ao_i[d][11:2]];
            e_ir[d]  <= ir_i[d];
            e_pc4[d] <= pc4_i[d];
            e_ao[d]  <= ao_i[d];
            e_exc[d] <= mis;
            e_dr[d]  <= mis ? 32'h0 : load_f(op_i[d], old, ao_i[d]);
            if (rq && op_i[d] >= 6) begin
              sd = fwd_i[d] ? wd_i[d] : rt_i[d];
              nw = store_f(op_i[d], old, sd, ao_i[d]);
              mm[d][ao_i[d][11:2]] <= nw;
              $display("%0t store lat=%0d pc=%h addr=%h word=%h", $time, lat_of(d),
                       pc4_i[d] - 32'd4, {ao_i[d][31:2], 2'b00}, nw);
            end
          end
        end
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : compare
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        logic e_st;
        e_st = request_now(d) && (age[d] < lat_of(d));
        chk($sformatf("dut%0d StallM", d), 32'(stall_o[d]), 32'(e_st));
        chk($sformatf("dut%0d IRW", d), irw_o[d], e_ir[d]);
        chk($sformatf("dut%0d PC4W", d), pc4w_o[d], e_pc4[d]);
        chk($sformatf("dut%0d AOW", d), aow_o[d], e_ao[d]);
        chk($sformatf("dut%0d DRW", d), drw_o[d], e_dr[d]);
        chk($sformatf("dut%0d AddrExcW", d), 32'(exc_o[d]), 32'(e_exc[d]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(int d, logic [3:0] op, logic [31:0] ao, logic [31:0] rt,
                        logic fwd, logic [31:0] wd, logic kill);
    tag++;
    ir_i[d]   = {4'hE, op, 24'(tag)};
    pc4_i[d]  = 32'h0000_1000 + 32'(4 * tag);
    op_i[d]   = op;
    ao_i[d]   = ao;
    rt_i[d]   = rt;
    fwd_i[d]  = fwd;
    wd_i[d]   = wd;
    kill_i[d] = kill;
  endtask

  task automatic idle(int d);
    op_i[d] = 4'd0; kill_i[d] = 1'b0; fwd_i[d] = 1'b0;
  endtask

  task automatic wait_done(int d, output int stalls);
    bit s;
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      s = stall_o[d];
      step();
      if (s) stalls++;
      else return;
    end
    total++;
    bad++;
    $display("FAIL dut%0d completion timeout: stalled %0d cycles, want at most 7", d, stalls);
  endtask

  task automatic run_op(int d, logic [3:0] op, logic [31:0] ao, logic [31:0] rt,
                        logic fwd, logic [31:0] wd, output int stalls);
    set_op(d, op, ao, rt, fwd, wd, 1'b0);
    wait_done(d, stalls);
  endtask

  task automatic lit_dr(string nm, int d, logic [31:0] exp);
    chk({nm, " dut"}, drw_o[d], exp);
    chk({nm, " model"}, e_dr[d], exp);
  endtask

  initial begin
    int st;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      ir_i[d] = '0; pc4_i[d] = '0; ao_i[d] = '0; rt_i[d] = '0; wd_i[d] = '0;
      op_i[d] = '0; fwd_i[d] = 1'b0; kill_i[d] = 1'b0;
    end
    step();
    chk_en = 1'b1;
    step();
    chk("reset IRW", irw_o[0], 32'h0);
    chk("reset DRW", drw_o[1], 32'h0);
    rst_n = 1'b1;

    // zero latency: word store/load, byte lanes, halfword, misaligned
    run_op(0, 4'd6, 32'h10, 32'hAABBCCDD, 1'b0, 32'h0, st);
    chk("T1 SW stalls", 32'(st), 32'd0);
    run_op(0, 4'd1, 32'h10, 32'h0, 1'b0, 32'h0, st);
    chk("T1 LW stalls", 32'(st), 32'd0);
    lit_dr("T1 LW", 0, 32'hAABBCCDD);
    run_op(0, 4'd8, 32'h11, 32'h000000EE, 1'b0, 32'h0, st);
    run_op(0, 4'd4, 32'h11, 32'h0, 1'b0, 32'h0, st);
    lit_dr("T2 LB", 0, 32'hFFFFFFEE);
    run_op(0, 4'd5, 32'h11, 32'h0, 1'b0, 32'h0, st);
    lit_dr("T2 LBU", 0, 32'h000000EE);
    run_op(0, 4'd1, 32'h10, 32'h0, 1'b0, 32'h0, st);
    lit_dr("T2 LW", 0, 32'hAABBEEDD);
    run_op(0, 4'd2, 32'h12, 32'h0, 1'b0, 32'h0, st);
    lit_dr("T3 LH", 0, 32'hFFFFAABB);
    run_op(0, 4'd3, 32'h11, 32'h0, 1'b0, 32'h0, st);
    lit_dr("T3 LHU misaligned", 0, 32'h0);
    chk("T3 AddrExcW", 32'(exc_o[0]), 32'd1);
    run_op(0, 4'd7, 32'h16, 32'h0000_1234, 1'b0, 32'h0, st);
    run_op(0, 4'd1, 32'h14, 32'h0, 1'b0, 32'h0, st);
    lit_dr("SH upper lane", 0, 32'h1234_0000);
    run_op(0, 4'd6, 32'h1A, 32'h5555_5555, 1'b0, 32'h0, st);
    chk("misaligned SW exc", 32'(exc_o[0]), 32'd1);
    run_op(0, 4'd1, 32'h18, 32'h0, 1'b0, 32'h0, st);
    lit_dr("misaligned SW no write", 0, 32'h0);
    run_op(0, 4'd12, 32'h10, 32'h0, 1'b0, 32'h0, st);
    lit_dr("op 12 passthrough", 0, 32'h0);
    idle(0);

    // latency 3: forwarded store data, stall length, read-back
    run_op(1, 4'd6, 32'h20, 32'hDEAD_BEEF, 1'b1, 32'h12345678, st);
    chk("T4 SW stalls", 32'(st), 32'd3);
    run_op(1, 4'd1, 32'h20, 32'h0, 1'b0, 32'h0, st);
    chk("T4 LW stalls", 32'(st), 32'd3);
    lit_dr("T4 LW", 1, 32'h12345678);
    run_op(1, 4'd9, 32'h20, 32'h0, 1'b0, 32'h0, st);
    chk("op 9 stalls", 32'(st), 32'd0);

    // reset in the 2nd wait cycle aborts the store
    set_op(1, 4'd6, 32'h20, 32'h0000_0077, 1'b0, 32'h0, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle(1);
    #1;
    chk("T5 IRW", irw_o[1], 32'h0);
    chk("T5 DRW", drw_o[1], 32'h0);
    chk("T5 StallM", 32'(stall_o[1]), 32'd0);
    run_op(1, 4'd1, 32'h20, 32'h0, 1'b0, 32'h0, st);
    lit_dr("T5 LW after abort", 1, 32'h0);

    // kill in IDLE drops the store; kill during WAIT is ignored
    set_op(1, 4'd6, 32'h24, 32'h0000_0055, 1'b0, 32'h0, 1'b1);
    #1;
    chk("T6 kill StallM", 32'(stall_o[1]), 32'd0);
    step();
    chk("T6 kill IRW", irw_o[1], 32'h0);
    run_op(1, 4'd1, 32'h24, 32'h0, 1'b0, 32'h0, st);
    lit_dr("T6 killed store", 1, 32'h0);
    set_op(1, 4'd6, 32'h30, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
    step();
    kill_i[1] = 1'b1;
    wait_done(1, st);
    chk("T6 remaining stalls", 32'(st), 32'd2);
    kill_i[1] = 1'b0;
    run_op(1, 4'd1, 32'h30, 32'h0, 1'b0, 32'h0, st);
    lit_dr("T6 LW after mid-WAIT kill", 1, 32'hCAFEF00D);
    run_op(1, 4'd4, 32'h33, 32'h0, 1'b0, 32'h0, st);
    lit_dr("L3 LB lane 3", 1, 32'hFFFFFFCA);
    idle(1);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
